// File: rtl/shift_arbiter.sv
// Two-requester arbiter in front of one shared 32-bit barrel shifter.
// IDLE grants and latches operands, EXEC registers the shift result, RESP holds it until accepted.
module shift_arbiter #(
  parameter int FIXED_PRI = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] a0,
  input  logic [31:0] a1,
  input  logic [4:0]  b0,
  input  logic [4:0]  b1,
  input  logic [1:0]  aluc0,
  input  logic [1:0]  aluc1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] res,
  output logic        res_id,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        busy,
  output logic [1:0]  state_o
);

  // Handshakes: a requester holds reqN high until the one-cycle ackN, which is only
  // issued in IDLE; the result transfers on a rising edge where res_valid and res_ready
  // are both high, and res/res_id/res_valid stay stable until that edge.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [4:0]  b_q, b_d;
  logic [1:0]  aluc_q, aluc_d;
  logic        id_q, id_d;
  logic        last_id_q, last_id_d;
  logic [31:0] res_q, res_d;
  logic        res_id_q, res_id_d;
  logic        res_valid_q, res_valid_d;

  logic        any_req;
  logic        grant_id;
  logic        ack0_c, ack1_c;
  logic [31:0] shift_out;

  // Shared barrel shifter: left shifts reuse the right-shift stages on a bit-reversed word.
  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[i] = x[31-i];
    return y;
  endfunction

  logic              shl;
  logic              fill;
  logic [5:0][31:0]  stage;

  assign shl      = aluc_q[0];
  assign fill     = (aluc_q == 2'b00) & a_q[31];
  assign stage[0] = shl ? rev32(a_q) : a_q;

  for (genvar k = 0; k < 5; k++) begin : g_stage
    localparam int SH = 1 << k;
    assign stage[k+1] = b_q[k] ? {{SH{fill}}, stage[k][31:SH]} : stage[k];
  end

  assign shift_out = shl ? rev32(stage[5]) : stage[5];

  // A lone requester always wins; ties go by FIXED_PRI or away from the last grant.
  always_comb begin
    any_req  = req0 | req1;
    grant_id = ~req0;
    if (req0 && req1) begin
      grant_id = (FIXED_PRI != 0) ? 1'b0 : ~last_id_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    aluc_d      = aluc_q;
    id_d        = id_q;
    last_id_d   = last_id_q;
    res_d       = res_q;
    res_id_d    = res_id_q;
    res_valid_d = res_valid_q;
    ack0_c      = 1'b0;
    ack1_c      = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d   = EXEC;
          id_d      = grant_id;
          last_id_d = grant_id;
          a_d       = grant_id ? a1 : a0;
          b_d       = grant_id ? b1 : b0;
          aluc_d    = grant_id ? aluc1 : aluc0;
          ack0_c    = ~grant_id;
          ack1_c    = grant_id;
        end
      end
      EXEC: begin
        res_d       = shift_out;
        res_id_d    = id_q;
        res_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        res_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      aluc_q      <= '0;
      id_q        <= 1'b0;
      last_id_q   <= 1'b1;
      res_q       <= '0;
      res_id_q    <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      aluc_q      <= aluc_d;
      id_q        <= id_d;
      last_id_q   <= last_id_d;
      res_q       <= res_d;
      res_id_q    <= res_id_d;
      res_valid_q <= res_valid_d;
    end
  end

  // Acks are combinational from IDLE, so they are masked while reset is held.
  assign ack0      = ack0_c & ~rst;
  assign ack1      = ack1_c & ~rst;
  assign res       = res_q;
  assign res_id    = res_id_q;
  assign res_valid = res_valid_q;
  assign busy      = (state_q != IDLE);
  assign state_o   = state_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed scenarios plus a randomized run against a
// transaction-level model (arithmetic shift reference, arbitration by request/last-grant rules).
module tb_shift_arbiter;

  logic        clk;
  logic        rst;
  logic        req0, req1;
  logic [31:0] a0, a1;
  logic [4:0]  b0, b1;
  logic [1:0]  aluc0, aluc1;
  logic        res_ready;

  logic        ack0, ack1, res_id, res_valid, busy;
  logic [31:0] res;
  logic [1:0]  state_o;

  logic        fp_ack0, fp_ack1, fp_res_id, fp_res_valid, fp_busy;
  logic [31:0] fp_res;
  logic [1:0]  fp_state;

  int n_vec = 0;
  int n_err = 0;

  logic [32:0] exp_q[$];

  shift_arbiter #(.FIXED_PRI(0)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1), .aluc0(aluc0), .aluc1(aluc1),
    .ack0(ack0), .ack1(ack1), .res(res), .res_id(res_id), .res_valid(res_valid),
    .res_ready(res_ready), .busy(busy), .state_o(state_o)
  );

  shift_arbiter #(.FIXED_PRI(1)) dut_fp (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1), .aluc0(aluc0), .aluc1(aluc1),
    .ack0(fp_ack0), .ack1(fp_ack1), .res(fp_res), .res_id(fp_res_id), .res_valid(fp_res_valid),
    .res_ready(res_ready), .busy(fp_busy), .state_o(fp_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference shift computed with integer arithmetic (floor division / multiplication).
  function automatic logic [31:0] shift_model(input logic [31:0] a, input logic [4:0] b,
                                              input logic [1:0] aluc);
    longint p;
    longint v;
    logic [63:0] r;
    p = longint'(64'd1 << b);
    if (aluc == 2'b00) begin
      v = longint'($signed(a));
      if (v < 0) v = -((-v + p - 1) / p);
      else       v = v / p;
    end else if (aluc == 2'b10) begin
      v = longint'({32'd0, a}) / p;
    end else begin
      v = longint'({32'd0, a}) * p;
    end
    r = 64'(v);
    return r[31:0];
  endfunction

  function automatic logic [4:0] pick_b();
    int s;
    s = $urandom_range(0, 3);
    if (s == 0) return 5'd0;
    if (s == 1) return 5'd31;
    return 5'($urandom_range(0, 31));
  endfunction

  // driver tasks
  task automatic apply_reset();
    rst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Runs one isolated op (DUT idle, caller at posedge+1) and returns what was observed.
  task automatic run_op(input logic id, input logic [31:0] a, input logic [4:0] b,
                        input logic [1:0] aluc, output logic acked, output logic v_exec,
                        output logic v_resp, output logic [31:0] r, output logic rid);
    res_ready = 1'b1;
    if (id) begin
      req0 = 1'b0; req1 = 1'b1; a1 = a; b1 = b; aluc1 = aluc;
    end else begin
      req1 = 1'b0; req0 = 1'b1; a0 = a; b0 = b; aluc0 = aluc;
    end
    @(negedge clk);
    acked = id ? (ack1 && !ack0) : (ack0 && !ack1);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = ~a; a1 = ~a; b0 = ~b; b1 = ~b; aluc0 = ~aluc; aluc1 = ~aluc;
    @(negedge clk);
    v_exec = res_valid;
    @(posedge clk); #1;
    @(negedge clk);
    v_resp = res_valid;
    r = res;
    rid = res_id;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; res_ready = 1'b1;
    a0 = 32'h1234_5678; a1 = 32'h8765_4321; b0 = 5'd3; b1 = 5'd7; aluc0 = 2'b00; aluc1 = 2'b01;
    #2;
    n_vec++; if (ack0 !== 1'b0 || ack1 !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b%b want 00", ack0, ack1); end
    n_vec++; if (res !== 32'h0) begin n_err++; $display("FAIL reset_res: got %h want 00000000", res); end
    n_vec++; if (res_id !== 1'b0 || res_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid_id: got id=%b v=%b want 0 0", res_id, res_valid); end
    n_vec++; if (busy !== 1'b0 || fp_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b/%b want 0/0", busy, fp_busy); end
    @(negedge clk);
    n_vec++; if (ack0 !== 1'b0 || fp_ack0 !== 1'b0) begin n_err++; $display("FAIL reset_clocked_ack: got %b/%b want 0/0", ack0, fp_ack0); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_vec++; if ({ack0, ack1} !== 2'b10) begin n_err++; $display("FAIL first_tie_grant: got ack0/1=%b%b want 10", ack0, ack1); end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_arith_basic();
    logic acked, v_exec, v_resp, rid;
    logic [31:0] r;
    apply_reset();
    run_op(1'b0, 32'h8000_0000, 5'd4, 2'b00, acked, v_exec, v_resp, r, rid);
    n_vec++; if (acked !== 1'b1) begin n_err++; $display("FAIL arith_ack: got %b want 1", acked); end
    n_vec++; if (v_exec !== 1'b0 || v_resp !== 1'b1) begin n_err++; $display("FAIL arith_latency: got exec=%b resp=%b want 0 1", v_exec, v_resp); end
    n_vec++; if (r !== 32'hF800_0000 || rid !== 1'b0) begin n_err++; $display("FAIL arith_res: got %h id %b want f8000000 id 0", r, rid); end
    @(negedge clk);
    n_vec++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL arith_one_cycle: got v=%b busy=%b want 0 0", res_valid, busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_req1_ops();
    logic acked, v_exec, v_resp, rid;
    logic [31:0] r;
    apply_reset();
    run_op(1'b1, 32'h8000_0000, 5'd4, 2'b10, acked, v_exec, v_resp, r, rid);
    n_vec++; if (acked !== 1'b1 || v_resp !== 1'b1) begin n_err++; $display("FAIL lsr_hs: got ack=%b v=%b want 1 1", acked, v_resp); end
    n_vec++; if (r !== 32'h0800_0000 || rid !== 1'b1) begin n_err++; $display("FAIL lsr_res: got %h id %b want 08000000 id 1", r, rid); end
    run_op(1'b1, 32'h0000_0001, 5'd31, 2'b01, acked, v_exec, v_resp, r, rid);
    n_vec++; if (r !== 32'h8000_0000 || rid !== 1'b1) begin n_err++; $display("FAIL shl_res: got %h id %b want 80000000 id 1", r, rid); end
  endtask

  task automatic test_boundaries();
    logic acked, v_exec, v_resp, rid;
    logic [31:0] r, a, e;
    logic [4:0] b;
    logic [1:0] aluc;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      a = $urandom | 32'h8000_0000;
      aluc = 2'(i % 4);
      b = (i < 4) ? 5'd0 : ((i < 6) ? 5'd31 : pick_b());
      e = shift_model(a, b, aluc);
      run_op(1'(i % 2), a, b, aluc, acked, v_exec, v_resp, r, rid);
      n_vec++; if (r !== e || v_resp !== 1'b1) begin n_err++; $display("FAIL boundary_%0d: got %h v=%b want %h (a=%h b=%0d aluc=%b)", i, r, v_resp, e, a, b, aluc); end
      if (i == 4) begin
        n_vec++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL asr31_neg: got %h want ffffffff", r); end
      end
      if (i < 4) begin
        n_vec++; if (r !== a) begin n_err++; $display("FAIL shift0_aluc%0d: got %h want %h", i, r, a); end
      end
    end
  endtask

  task automatic test_priority();
    logic e_rr0, e_rr1, e_fp0;
    apply_reset();
    a0 = 32'h0000_00F0; b0 = 5'd2; aluc0 = 2'b10;
    a1 = 32'h0000_000F; b1 = 5'd2; aluc1 = 2'b01;
    req0 = 1'b1; req1 = 1'b1; res_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      e_rr0 = (k % 3 == 0) && ((k / 3) % 2 == 0);
      e_rr1 = (k % 3 == 0) && ((k / 3) % 2 == 1);
      e_fp0 = (k % 3 == 0);
      n_vec++; if ({ack0, ack1} !== {e_rr0, e_rr1}) begin n_err++; $display("FAIL rr_ack_c%0d: got %b%b want %b%b", k, ack0, ack1, e_rr0, e_rr1); end
      n_vec++; if ({fp_ack0, fp_ack1} !== {e_fp0, 1'b0}) begin n_err++; $display("FAIL fixed_ack_c%0d: got %b%b want %b0", k, fp_ack0, fp_ack1, e_fp0); end
      @(posedge clk); #1;
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    apply_reset();
    res_ready = 1'b0;
    req0 = 1'b1; a0 = 32'hC000_1234; b0 = 5'd9; aluc0 = 2'b00;
    e = shift_model(a0, b0, aluc0);
    @(negedge clk);
    n_vec++; if (ack0 !== 1'b1) begin n_err++; $display("FAIL bp_ack0: got %b want 1", ack0); end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b1; a1 = 32'h0000_0003; b1 = 5'd1; aluc1 = 2'b11;
    @(negedge clk);
    n_vec++; if (ack1 !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL bp_exec: got ack1=%b busy=%b want 0 1", ack1, busy); end
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      a0 = $urandom;
      @(negedge clk);
      n_vec++; if (res_valid !== 1'b1 || res !== e || res_id !== 1'b0) begin n_err++; $display("FAIL bp_hold_c%0d: got v=%b %h id %b want 1 %h id 0", k, res_valid, res, res_id, e); end
      n_vec++; if (busy !== 1'b1 || ack0 !== 1'b0 || ack1 !== 1'b0) begin n_err++; $display("FAIL bp_noack_c%0d: got busy=%b ack=%b%b want 1 00", k, busy, ack0, ack1); end
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (res_valid !== 1'b1 || ack1 !== 1'b0) begin n_err++; $display("FAIL bp_accept: got v=%b ack1=%b want 1 0", res_valid, ack1); end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (ack1 !== 1'b1 || res_valid !== 1'b0) begin n_err++; $display("FAIL bp_next_grant: got ack1=%b v=%b want 1 0", ack1, res_valid); end
    @(posedge clk); #1;
    req1 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset_mid_op();
    logic acked, v_exec, v_resp, rid;
    logic [31:0] r;
    apply_reset();
    req0 = 1'b1; a0 = 32'hFFFF_0000; b0 = 5'd8; aluc0 = 2'b00;
    @(posedge clk); #1;
    req0 = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_vec++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rst_exec: got v=%b busy=%b want 0 0", res_valid, busy); end
    @(posedge clk); #1 rst = 1'b0;
    res_ready = 1'b0;
    req0 = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    req0 = 1'b0;
    @(negedge clk);
    n_vec++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL rst_resp_setup: got v=%b want 1", res_valid); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (res_valid !== 1'b0 || busy !== 1'b0 || res !== 32'h0) begin n_err++; $display("FAIL rst_resp: got v=%b busy=%b res=%h want 0 0 00000000", res_valid, busy, res); end
    @(posedge clk); #1 rst = 1'b0;
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_vec++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rst_no_result_c%0d: got v=%b busy=%b want 0 0", k, res_valid, busy); end
      @(posedge clk); #1;
    end
    run_op(1'b1, 32'h0F0F_0000, 5'd4, 2'b01, acked, v_exec, v_resp, r, rid);
    n_vec++; if (acked !== 1'b1 || v_resp !== 1'b1 || r !== 32'hF0F0_0000 || rid !== 1'b1) begin n_err++; $display("FAIL rst_recover: got ack=%b v=%b %h id %b want 1 1 f0f00000 id 1", acked, v_resp, r, rid); end
  endtask

  task automatic test_operand_hold();
    logic [31:0] e;
    apply_reset();
    req0 = 1'b1; a0 = 32'h9000_0001; b0 = 5'd3; aluc0 = 2'b00;
    e = shift_model(32'h9000_0001, 5'd3, 2'b00);
    @(negedge clk);
    n_vec++; if (ack0 !== 1'b1) begin n_err++; $display("FAIL hold_ack0: got %b want 1", ack0); end
    @(posedge clk); #1;
    req0 = 1'b0; a0 = 32'h0000_0001; b0 = 5'd0; aluc0 = 2'b01;
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (res !== e || res_valid !== 1'b1) begin n_err++; $display("FAIL hold_res: got %h v=%b want %h 1", res, res_valid, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic p0, p1, outstanding, w, e_ack0, e_ack1, e_valid, e_busy;
    int valid_from, last_id;
    logic [32:0] head;
    apply_reset();
    exp_q.delete();
    p0 = 1'b0; p1 = 1'b0; outstanding = 1'b0; valid_from = 0; last_id = 1;
    for (int t = 0; t < 400; t++) begin
      if (!p0) begin
        a0 = $urandom; b0 = pick_b(); aluc0 = 2'($urandom_range(0, 3));
        p0 = ($urandom_range(0, 2) == 0);
      end
      if (!p1) begin
        a1 = $urandom; b1 = pick_b(); aluc1 = 2'($urandom_range(0, 3));
        p1 = ($urandom_range(0, 2) == 0);
      end
      req0 = p0; req1 = p1;
      res_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      e_busy  = outstanding;
      e_valid = outstanding && (t >= valid_from);
      e_ack0  = 1'b0; e_ack1 = 1'b0; w = 1'b0;
      if (!outstanding && (p0 || p1)) begin
        w = (p0 && p1) ? (last_id == 0) : p1;
        e_ack0 = ~w; e_ack1 = w;
      end
      n_vec++; if ({ack0, ack1} !== {e_ack0, e_ack1}) begin n_err++; $display("FAIL rand_ack_t%0d: got %b%b want %b%b", t, ack0, ack1, e_ack0, e_ack1); end
      n_vec++; if (res_valid !== e_valid || busy !== e_busy) begin n_err++; $display("FAIL rand_state_t%0d: got v=%b busy=%b want %b %b", t, res_valid, busy, e_valid, e_busy); end
      if (e_valid) begin
        head = exp_q[0];
        n_vec++; if ({res_id, res} !== head) begin n_err++; $display("FAIL rand_res_t%0d: got id %b %h want id %b %h", t, res_id, res, head[32], head[31:0]); end
        if (res_ready) begin
          void'(exp_q.pop_front());
          outstanding = 1'b0;
        end
      end
      if (e_ack0 || e_ack1) begin
        exp_q.push_back({w, w ? shift_model(a1, b1, aluc1) : shift_model(a0, b0, aluc0)});
        outstanding = 1'b1;
        valid_from = t + 2;
        last_id = w ? 1 : 0;
        if (w) p1 = 1'b0; else p0 = 1'b0;
      end
      @(posedge clk); #1;
    end
    req0 = 1'b0; req1 = 1'b0; res_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  initial begin
    test_reset();
    test_arith_basic();
    test_req1_ops();
    test_boundaries();
    test_priority();
    test_backpressure();
    test_reset_mid_op();
    test_operand_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
